// File: rtl/alu_trace_recorder.sv
// Buffers ALU transactions (f, a, b, y, zero) and replays them as a word stream
// in alu.tv order: {zeros,f}, a, b, y, {zeros,zero} for each stored record.
module alu_trace_recorder #(
  parameter int DEPTH = 20,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap_valid,
  output logic                       cap_ready,
  input  logic [2:0]                 cap_f,
  input  logic [WIDTH-1:0]           cap_a,
  input  logic [WIDTH-1:0]           cap_b,
  input  logic [WIDTH-1:0]           cap_y,
  input  logic                       cap_zero,
  input  logic                       clear,
  input  logic                       rd_start,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_last,
  output logic [$clog2(DEPTH+1)-1:0] rec_count,
  output logic                       full,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CAPTURE, DUMP} state_t;

  state_t r_state, w_stateNext;

  logic [2:0]       r_memF [DEPTH];
  logic [WIDTH-1:0] r_memA [DEPTH];
  logic [WIDTH-1:0] r_memB [DEPTH];
  logic [WIDTH-1:0] r_memY [DEPTH];
  logic             r_memZ [DEPTH];

  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_rdValid;
  logic             r_rdLast;
  logic [WIDTH-1:0] r_rdData;
  logic [IW-1:0]    r_recIdx;
  logic [2:0]       r_wordIdx;

  logic             w_full;
  logic             w_capReady;
  logic             w_capFire;
  logic [CW-1:0]    w_countNext;
  logic             w_start;
  logic             w_adv;
  logic [IW-1:0]    w_nextRec;
  logic [2:0]       w_nextWord;
  logic [WIDTH-1:0] w_nextData;
  logic             w_nextLast;
  logic [2:0]       w_startF;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_capReady  = (r_state == CAPTURE) && !w_full && !clear;
  assign w_capFire   = cap_valid && w_capReady;
  assign w_countNext = r_count + CW'(w_capFire);
  // A capture in the same cycle as rd_start counts toward the dump decision.
  assign w_start     = (r_state == CAPTURE) && !clear && rd_start && (w_countNext != '0);
  assign w_adv       = r_rdValid && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= CAPTURE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      CAPTURE: if (w_start) w_stateNext = DUMP;
      DUMP:    if (w_adv && r_rdLast) w_stateNext = CAPTURE;
      default: w_stateNext = CAPTURE;
    endcase
    if (clear) w_stateNext = CAPTURE;
  end

  always_ff @(posedge clk) begin
    if (w_capFire) begin
      r_memF[r_count[IW-1:0]] <= cap_f;
      r_memA[r_count[IW-1:0]] <= cap_a;
      r_memB[r_count[IW-1:0]] <= cap_b;
      r_memY[r_count[IW-1:0]] <= cap_y;
      r_memZ[r_count[IW-1:0]] <= cap_zero;
    end
  end

  always_comb begin
    w_nextRec  = r_recIdx;
    w_nextWord = r_wordIdx + 3'd1;
    if (r_wordIdx == 3'd4) begin
      w_nextRec  = r_recIdx + IW'(1);
      w_nextWord = 3'd0;
    end
    case (w_nextWord)
      3'd0:    w_nextData = {{(WIDTH-3){1'b0}}, r_memF[w_nextRec]};
      3'd1:    w_nextData = r_memA[w_nextRec];
      3'd2:    w_nextData = r_memB[w_nextRec];
      3'd3:    w_nextData = r_memY[w_nextRec];
      default: w_nextData = {{(WIDTH-1){1'b0}}, r_memZ[w_nextRec]};
    endcase
    w_nextLast = (w_nextWord == 3'd4) && (CW'(w_nextRec) == r_count - CW'(1));
    // An empty buffer can only start a dump via a same-cycle capture, not yet in memory.
    w_startF   = (r_count == '0) ? cap_f : r_memF[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rdValid  <= 1'b0;
      r_rdLast   <= 1'b0;
      r_rdData   <= '0;
      r_recIdx   <= '0;
      r_wordIdx  <= 3'd0;
    end else if (clear) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rdValid  <= 1'b0;
      r_rdLast   <= 1'b0;
      r_rdData   <= '0;
      r_recIdx   <= '0;
      r_wordIdx  <= 3'd0;
    end else begin
      r_count <= w_countNext;
      if (cap_valid && w_full && (r_state == CAPTURE)) r_overflow <= 1'b1;
      if (w_start) begin
        r_rdValid <= 1'b1;
        r_rdLast  <= 1'b0;
        r_rdData  <= {{(WIDTH-3){1'b0}}, w_startF};
        r_recIdx  <= '0;
        r_wordIdx <= 3'd0;
      end else if (w_adv) begin
        if (r_rdLast) begin
          r_rdValid <= 1'b0;
          r_rdLast  <= 1'b0;
        end else begin
          r_rdData  <= w_nextData;
          r_rdLast  <= w_nextLast;
          r_recIdx  <= w_nextRec;
          r_wordIdx <= w_nextWord;
        end
      end
    end
  end

  assign cap_ready = w_capReady;
  assign rd_valid  = r_rdValid;
  assign rd_data   = r_rdData;
  assign rd_last   = r_rdLast;
  assign rec_count = r_count;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule
